inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit that consumes the program counter and returns instructions to decode. Each cycle it turns the current `pc_addr_i` into a single-outstanding request on the instruction bus and registers the returned word with its address for the decode stage. It drives `fetch_hold_o` back into the PC hold logic so the PC advances only when the instruction for the current address has been accepted. On a jump it flushes any in-flight or buffered instruction.

## Interface
- `ADDR_W`, 32, instruction address width
- `DATA_W`, 32, instruction word width
- `HOLD_W`, 3, width of the pipeline hold bus
- `NOP_INST`, 32'h0000_0013, word driven on `inst_o` when no valid instruction is present

Ports:
- `clk_i`  in  1  the block's only clock; all state updates on its rising edge
- `rst_n_i`  in  1  reset, synchronous and active-low
- `pc_addr_i`  in  ADDR_W  current PC value
- `hold_flag_i`  in  HOLD_W  downstream hold; any bit set means decode cannot accept
- `jump_flag_i`  in  1  jump/flush; the PC loads its target on the same edge
- `ibus_req_o`  out  1  instruction bus request
- `ibus_addr_o`  out  ADDR_W  request address, combinational copy of `pc_addr_i`
- `ibus_gnt_i`  in  1  request accepted this cycle
- `ibus_rvalid_i`  in  1  read data valid
- `ibus_rdata_i`  in  DATA_W  read data
- `inst_o`  out  DATA_W  registered instruction to decode
- `inst_addr_o`  out  ADDR_W  address of `inst_o`
- `inst_valid_o`  out  1  `inst_o` holds a real fetched instruction
- `fetch_hold_o`  out  1  hold request to the PC

## Operation
- States:
  - IDLE: one cycle after reset, then REQ.
  - REQ: `ibus_req_o`=1 with `ibus_addr_o`=`pc_addr_i`. Goes to WAIT when `ibus_gnt_i`=1. The request stays asserted until it is granted.
  - WAIT: waiting for `ibus_rvalid_i`.
  - HOLD: a response was captured into the internal buffer (data and address) while `hold_flag_i`≠0.
- Only one request is outstanding. `ibus_rvalid_i` is ignored outside WAIT.
- WAIT with rvalid=1, drop=0, hold=0: load `inst_o` with rdata, `inst_addr_o` with the captured request address, and set `inst_valid_o`=1. Next state is REQ.
- WAIT with rvalid=1, drop=0, hold≠0: store the response in the buffer and go to HOLD. `inst_o`, `inst_addr_o` and `inst_valid_o` are unchanged.
- HOLD with hold=0: load the outputs from the buffer, then go to REQ.
- `fetch_hold_o` is combinational:
  - It is 0 in the cycle an instruction is delivered to `inst_o` (from WAIT or from HOLD).
  - It is 0 in any cycle with `jump_flag_i`=1, so the PC can take the jump.
  - It is 1 otherwise, including IDLE.
- Jump handling, by state:
  - REQ with gnt=1: go to WAIT with the drop flag set.
  - REQ with gnt=0: stay in REQ. The address follows the new PC on the next cycle.
  - WAIT: set drop. If rvalid arrives in the same cycle, discard it and go to REQ.
  - HOLD: discard the buffer and go to REQ.
  - In every case, on the next edge `inst_o`=NOP_INST and `inst_valid_o`=0.
- WAIT with drop=1 and rvalid=1: discard the data, clear drop, go to REQ, leave the outputs unchanged.
- A jump takes priority over hold and over delivery in the same cycle.
- When not delivering, `inst_valid_o` keeps its value while `hold_flag_i`≠0. Otherwise it clears to 0 on the edge after a delivery cycle.

## Timing
- Reset values: state=IDLE, drop=0, `ibus_req_o`=0, `inst_o`=NOP_INST, `inst_addr_o`=0, `inst_valid_o`=0, `fetch_hold_o`=1.
- The first request is issued in the second cycle after `rst_n_i` rises.
- With gnt in cycle N and rvalid in cycle N+1, `inst_o` is valid from edge N+2. Peak throughput is one instruction per 2 cycles.
- If reset is asserted mid-transaction, all state returns to reset values. A late rvalid arrives in IDLE or REQ and is ignored.
- `ibus_addr_o` and `ibus_req_o` must not change while a request is pending, except by a jump.

## Test plan
- Reset, then zero-wait memory (gnt immediate, rvalid the next cycle), words 0xA0,0xA1,0xA2 -> `inst_addr_o` 0x0,0x4,0x8 each valid for one cycle, 2 cycles apart; `fetch_hold_o` low only in the rvalid cycles.
- `ibus_gnt_i` withheld 3 cycles at PC 0x0 -> `ibus_req_o` and `ibus_addr_o`=0x0 stable for 4 cycles; `fetch_hold_o` stays 1 throughout.
- rvalid with data 0x1234 while `hold_flag_i`=3'b010 for 2 cycles -> `inst_o` unchanged during the hold; 0x1234 appears on the edge after hold clears; no new request before that.
- `jump_flag_i` in WAIT at PC 0x8, target 0x100, stale rvalid 0xDEAD 2 cycles later -> 0xDEAD is never output; `inst_o`=NOP_INST with valid=0; the next request is at 0x100.
- Jump in REQ without gnt, target 0x40 -> `ibus_addr_o` is 0x40 the next cycle; exactly one response, delivered with `inst_addr_o`=0x40.
- `rst_n_i` low during WAIT, rvalid during reset -> all outputs at reset values; the first post-reset request is at the PC's reset address.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch: single-outstanding instruction fetch with hold buffer/flush  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inst_fetch #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_W   = 3,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              jump_flag_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              fetch_hold_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic              hold_any;
  logic              deliver;

  assign hold_any = |hold_flag_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      drop_q       <= 1'b0;
      req_addr_q   <= '0;
      buf_data_q   <= '0;
      buf_addr_q   <= '0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      req_addr_q   <= req_addr_d;
      buf_data_q   <= buf_data_d;
      buf_addr_q   <= buf_addr_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    req_addr_d   = req_addr_q;
    buf_data_d   = buf_data_q;
    buf_addr_d   = buf_addr_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = hold_any ? inst_valid_q : 1'b0;
    deliver      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // A jump with grant still lets the request complete, but marks it stale.
        if (ibus_gnt_i) begin
          state_d    = S_WAIT;
          req_addr_d = pc_addr_i;
          drop_d     = jump_flag_i;
        end
      end
      S_WAIT: begin
        if (ibus_rvalid_i) begin
          if (drop_q || jump_flag_i) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else if (hold_any) begin
            state_d    = S_HOLD;
            buf_data_d = ibus_rdata_i;
            buf_addr_d = req_addr_q;
          end else begin
            state_d     = S_REQ;
            deliver     = 1'b1;
            inst_d      = ibus_rdata_i;
            inst_addr_d = req_addr_q;
          end
        end else if (jump_flag_i) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (jump_flag_i) begin
          state_d = S_REQ;
        end else if (!hold_any) begin
          state_d     = S_REQ;
          deliver     = 1'b1;
          inst_d      = buf_data_q;
          inst_addr_d = buf_addr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) inst_valid_d = 1'b1;
    if (jump_flag_i) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end
  end

  assign ibus_req_o   = (state_q == S_REQ);
  assign ibus_addr_o  = pc_addr_i;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;
  assign fetch_hold_o = ~(deliver | jump_flag_i);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch: directed self-checking bench for inst_fetch               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] jtgt;
  logic [2:0]  hold;
  logic        jump;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        valid;
  logic        fhold;

  int tests = 0;
  int fails = 0;

  inst_fetch dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .pc_addr_i    (pc),
    .hold_flag_i  (hold),
    .jump_flag_i  (jump),
    .ibus_req_o   (req),
    .ibus_addr_o  (addr),
    .ibus_gnt_i   (gnt),
    .ibus_rvalid_i(rvalid),
    .ibus_rdata_i (rdata),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (valid),
    .fetch_hold_o (fhold)
  );

  always #5 clk = ~clk;

  // PC environment: reset to 0, load jump target, otherwise step when not held.
  always @(posedge clk) begin
    if (!rst_n)      pc <= 32'h0;
    else if (jump)   pc <= jtgt;
    else if (!fhold) pc <= pc + 32'd4;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; hold = 3'b000; jump = 1'b0; jtgt = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    repeat (3) cyc();
    chk("rst_inst", inst, NOP);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_fhold", {31'd0, fhold}, 32'd1);

    // First cycle after release is IDLE, second issues the request.
    rst_n = 1'b1; settle();
    chk("idle_req", {31'd0, req}, 32'd0);
    chk("idle_fhold", {31'd0, fhold}, 32'd1);
    cyc();

    // Grant withheld 3 cycles at PC 0x0.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) gnt = 1'b1;
      settle();
      chk("nognt_req", {31'd0, req}, 32'd1);
      chk("nognt_addr", addr, 32'h0);
      chk("nognt_fhold", {31'd0, fhold}, 32'd1);
      if (i < 3) cyc();
    end

    // Zero-wait memory: A0, A1, A2 at 0x0, 0x4, 0x8.
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hA0; settle();
    chk("zw0_fhold", {31'd0, fhold}, 32'd0);
    chk("zw0_req", {31'd0, req}, 32'd0);
    cyc(); rvalid = 1'b0; gnt = 1'b1; settle();
    chk("zw0_inst", inst, 32'hA0);
    chk("zw0_iaddr", inst_addr, 32'h0);
    chk("zw0_valid", {31'd0, valid}, 32'd1);
    chk("zw1_req", {31'd0, req}, 32'd1);
    chk("zw1_addr", addr, 32'h4);
    chk("zw1_fhold_req", {31'd0, fhold}, 32'd1);
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hA1; settle();
    chk("zw0_valid_clr", {31'd0, valid}, 32'd0);
    chk("zw1_fhold", {31'd0, fhold}, 32'd0);
    cyc(); rvalid = 1'b0; gnt = 1'b1; settle();
    chk("zw1_inst", inst, 32'hA1);
    chk("zw1_iaddr", inst_addr, 32'h4);
    chk("zw1_valid", {31'd0, valid}, 32'd1);
    chk("zw2_addr", addr, 32'h8);
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hA2; settle();
    chk("zw2_fhold", {31'd0, fhold}, 32'd0);
    cyc(); rvalid = 1'b0; settle();
    chk("zw2_inst", inst, 32'hA2);
    chk("zw2_iaddr", inst_addr, 32'h8);
    chk("zw2_valid", {31'd0, valid}, 32'd1);

    // Response under downstream hold for 2 cycles at PC 0xC.
    gnt = 1'b1;
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1234; hold = 3'b010; settle();
    chk("hold_fhold0", {31'd0, fhold}, 32'd1);
    cyc(); rvalid = 1'b0; settle();
    chk("hold_inst", inst, 32'hA2);
    chk("hold_valid", {31'd0, valid}, 32'd0);
    chk("hold_req", {31'd0, req}, 32'd0);
    chk("hold_fhold1", {31'd0, fhold}, 32'd1);
    hold = 3'b000; settle();
    chk("hold_rel_fhold", {31'd0, fhold}, 32'd0);
    cyc();
    chk("hold_out_inst", inst, 32'h1234);
    chk("hold_out_iaddr", inst_addr, 32'hC);
    chk("hold_out_valid", {31'd0, valid}, 32'd1);

    // Jump in WAIT to 0x100, stale response 2 cycles later.
    chk("jw_req_addr", addr, 32'h10);
    gnt = 1'b1;
    cyc(); gnt = 1'b0; jump = 1'b1; jtgt = 32'h100; settle();
    chk("jw_fhold", {31'd0, fhold}, 32'd0);
    cyc(); jump = 1'b0; settle();
    chk("jw_inst_nop", inst, NOP);
    chk("jw_valid", {31'd0, valid}, 32'd0);
    chk("jw_req_wait", {31'd0, req}, 32'd0);
    cyc(); rvalid = 1'b1; rdata = 32'hDEAD; settle();
    chk("jw_stale_fhold", {31'd0, fhold}, 32'd1);
    cyc(); rvalid = 1'b0; settle();
    chk("jw_stale_inst", inst, NOP);
    chk("jw_stale_valid", {31'd0, valid}, 32'd0);
    chk("jw_new_req", {31'd0, req}, 32'd1);
    chk("jw_new_addr", addr, 32'h100);
    gnt = 1'b1;
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h55;
    cyc(); rvalid = 1'b0; settle();
    chk("jw_tgt_inst", inst, 32'h55);
    chk("jw_tgt_iaddr", inst_addr, 32'h100);

    // Jump in REQ without grant to 0x40.
    jump = 1'b1; jtgt = 32'h40; settle();
    chk("jr_fhold", {31'd0, fhold}, 32'd0);
    cyc(); jump = 1'b0; settle();
    chk("jr_req", {31'd0, req}, 32'd1);
    chk("jr_addr", addr, 32'h40);
    chk("jr_inst_nop", inst, NOP);
    chk("jr_valid", {31'd0, valid}, 32'd0);
    gnt = 1'b1;
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h77;
    cyc(); rvalid = 1'b0; settle();
    chk("jr_inst", inst, 32'h77);
    chk("jr_iaddr", inst_addr, 32'h40);
    chk("jr_valid1", {31'd0, valid}, 32'd1);
    cyc();
    chk("jr_single", {31'd0, valid}, 32'd0);

    // Reset during WAIT with a response arriving during and after reset.
    gnt = 1'b1;
    cyc(); gnt = 1'b0; rst_n = 1'b0;
    cyc(); rvalid = 1'b1; rdata = 32'hBAD; settle();
    chk("mr_inst", inst, NOP);
    chk("mr_iaddr", inst_addr, 32'h0);
    chk("mr_valid", {31'd0, valid}, 32'd0);
    chk("mr_req", {31'd0, req}, 32'd0);
    chk("mr_fhold", {31'd0, fhold}, 32'd1);
    rst_n = 1'b1;
    cyc(); settle();
    chk("mr_first_req", {31'd0, req}, 32'd1);
    chk("mr_first_addr", addr, 32'h0);
    cyc(); rvalid = 1'b0; settle();
    chk("mr_late_inst", inst, NOP);
    chk("mr_late_valid", {31'd0, valid}, 32'd0);
    chk("mr_late_req", {31'd0, req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
